// File: rtl/cpu_seq_pkg.sv
// ============================================================================
// Module      : cpu_seq_pkg
// Description : Shared state encodings, default stage indices and helpers for
//               the multicycle stage sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_seq_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;

    localparam int STG_IFETCH   = 0;
    localparam int STG_REGFETCH = 1;
    localparam int STG_EXECUTE  = 2;
    localparam int STG_DATAMEM  = 3;
    localparam int STG_PCUPDATE = 4;

    function automatic int idxWidth(input int numStages);
        return (numStages > 1) ? $clog2(numStages) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_next_stage.sv
// ============================================================================
// Module      : seq_next_stage
// Description : Priority search for the stage that follows the current one.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_next_stage
    import cpu_seq_pkg::*;
#(
    parameter int NUM_STAGES = 5,
    parameter int IDX_W      = idxWidth(NUM_STAGES)
) (
    input  logic [IDX_W-1:0]      i_curIdx,
    input  logic [NUM_STAGES-1:0] i_skipEff,
    input  logic                  i_flushQual,
    output logic [IDX_W-1:0]      o_nextIdx,
    output logic                  o_wrap
);

    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NUM_STAGES - 1);

    logic w_found;

    always_comb begin
        o_wrap    = (i_curIdx == c_LAST_IDX);
        o_nextIdx = c_LAST_IDX;
        w_found   = 1'b0;
        if (o_wrap) begin
            o_nextIdx = '0;
        end else if (!i_flushQual) begin
            // The last stage is never skipped, so the search always lands.
            for (int j = 0; j < NUM_STAGES; j++) begin
                if (!w_found && (j > int'(i_curIdx)) && !i_skipEff[j]) begin
                    o_nextIdx = IDX_W'(j);
                    w_found   = 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/cpu_stage_sequencer.sv
// ============================================================================
// Module      : cpu_stage_sequencer
// Description : Parametrised multicycle control sequencer issuing per-stage
//               clock-enables. Optional stall timeout: CPU_SEQ_STALL_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_stage_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int NUM_STAGES     = 5,
    parameter int DECODE_STAGE   = 1,
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                          clk,
    input  logic                          nreset,
    input  logic                          run,
    input  logic [NUM_STAGES-1:0]         stage_ready,
    input  logic [NUM_STAGES-1:0]         stage_skip_mask,
    input  logic                          flush,
    output logic [NUM_STAGES-1:0]         stage_en,
    output logic [NUM_STAGES-1:0]         stage_adv,
    output logic [$clog2(NUM_STAGES)-1:0] cur_stage,
    output logic                          busy,
    output logic                          retire,
    output logic [CNT_W-1:0]              retire_cnt,
    output logic                          fault
);

    localparam int               c_IDX_W    = idxWidth(NUM_STAGES);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_STAGES - 1);
    localparam logic [c_IDX_W-1:0] c_DEC_IDX  = c_IDX_W'(DECODE_STAGE);

    logic [1:0]            r_state;
    logic [c_IDX_W-1:0]    r_idx;
    logic [NUM_STAGES-1:0] r_skip;
    logic [CNT_W-1:0]      r_retireCnt;

    logic                  w_running;
    logic                  w_curAdv;
    logic                  w_wrap;
    logic                  w_flushQual;
    logic [c_IDX_W-1:0]    w_nextIdx;
    logic [NUM_STAGES-1:0] w_allow;
    logic [NUM_STAGES-1:0] w_skipEff;

    // Only stages strictly between decode and PC update may be skipped.
    genvar g;
    generate
        for (g = 0; g < NUM_STAGES; g++) begin : g_allow
            assign w_allow[g] = (g > DECODE_STAGE) && (g < NUM_STAGES - 1);
        end
    endgenerate

    assign w_running   = (r_state == ST_RUN);
    assign stage_en    = w_running ? (NUM_STAGES'(1) << r_idx) : '0;
    assign stage_adv   = stage_en & stage_ready;
    assign w_curAdv    = |stage_adv;
    assign retire      = stage_adv[NUM_STAGES-1];
    assign busy        = w_running;
    assign cur_stage   = w_running ? r_idx : '0;
    assign retire_cnt  = r_retireCnt;
    assign w_skipEff   = ((r_idx == c_DEC_IDX) ? stage_skip_mask : r_skip) & w_allow;
    assign w_flushQual = flush && (r_idx >= c_DEC_IDX) && (r_idx != c_LAST_IDX);

    seq_next_stage #(
        .NUM_STAGES (NUM_STAGES),
        .IDX_W      (c_IDX_W)
    ) u_nextStage (
        .i_curIdx    (r_idx),
        .i_skipEff   (w_skipEff),
        .i_flushQual (w_flushQual),
        .o_nextIdx   (w_nextIdx),
        .o_wrap      (w_wrap)
    );

`ifdef CPU_SEQ_STALL_TIMEOUT_EN
    localparam int                c_WAIT_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LIMIT = c_WAIT_W'(TIMEOUT_CYCLES - 1);

    logic [c_WAIT_W-1:0] r_wait;
    logic                w_timeout;

    assign w_timeout = w_running && !w_curAdv && (r_wait == c_WAIT_LIMIT);
    assign fault     = (r_state == ST_FAULT);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_wait <= '0;
        end else if (!w_running || w_curAdv) begin
            r_wait <= '0;
        end else if (!w_timeout) begin
            r_wait <= r_wait + c_WAIT_W'(1);
        end
    end
`else
    logic w_timeout;

    assign w_timeout = 1'b0;
    assign fault     = 1'b0;
`endif

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_skip      <= '0;
            r_retireCnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_idx <= '0;
                    if (run) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_curAdv) begin
                        if (w_wrap) begin
                            r_retireCnt <= r_retireCnt + CNT_W'(1);
                            r_idx       <= '0;
                            if (!run) begin
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_idx <= w_nextIdx;
                        end
                    end else if (w_timeout) begin
                        r_state <= ST_FAULT;
                        r_idx   <= '0;
                    end
                end
                default: begin
                    r_idx <= '0;
                end
            endcase

            if (retire) begin
                r_skip <= '0;
            end else if (stage_adv[DECODE_STAGE]) begin
                r_skip <= stage_skip_mask & w_allow;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cpu_stage_sequencer.sv
// ============================================================================
// Module      : tb_cpu_stage_sequencer
// Description : Directed self-checking bench for cpu_stage_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_stage_sequencer;

    localparam int NS = 5;

    logic          clk;
    logic          nreset;
    logic          run;
    logic [NS-1:0] stage_ready;
    logic [NS-1:0] stage_skip_mask;
    logic          flush;
    logic [NS-1:0] stage_en;
    logic [NS-1:0] stage_adv;
    logic [2:0]    cur_stage;
    logic          busy;
    logic          retire;
    logic [3:0]    retire_cnt;
    logic          fault;

    int checks = 0;
    int errors = 0;

    cpu_stage_sequencer #(
        .NUM_STAGES     (NS),
        .DECODE_STAGE   (1),
        .CNT_W          (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk             (clk),
        .nreset          (nreset),
        .run             (run),
        .stage_ready     (stage_ready),
        .stage_skip_mask (stage_skip_mask),
        .flush           (flush),
        .stage_en        (stage_en),
        .stage_adv       (stage_adv),
        .cur_stage       (cur_stage),
        .busy            (busy),
        .retire          (retire),
        .retire_cnt      (retire_cnt),
        .fault           (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled here.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic runInstr(input int seq[], input string tag);
        for (int i = 0; i < seq.size(); i++) begin
            #1;
            chk({tag, " en"}, 32'(stage_en), 32'(1 << seq[i]));
            chk({tag, " cur"}, 32'(cur_stage), 32'(seq[i]));
            chk({tag, " retire"}, 32'(retire), 32'(i == seq.size() - 1));
            cyc();
        end
    endtask

    initial begin
        nreset          = 1'b0;
        run             = 1'b0;
        stage_ready     = '0;
        stage_skip_mask = '0;
        flush           = 1'b0;
        #3;
        chk("rst en", 32'(stage_en), 32'h0);
        chk("rst busy", 32'(busy), 32'h0);
        chk("rst cur", 32'(cur_stage), 32'h0);
        chk("rst cnt", 32'(retire_cnt), 32'h0);
        chk("rst fault", 32'(fault), 32'h0);
        chk("rst retire", 32'(retire), 32'h0);

        nreset      = 1'b1;
        run         = 1'b1;
        stage_ready = 5'b11111;
        #1;
        chk("idle cycle en", 32'(stage_en), 32'h0);
        cyc();

        runInstr('{0, 1, 2, 3, 4}, "full1");
        chk("cnt1", 32'(retire_cnt), 32'd1);
        runInstr('{0, 1, 2, 3, 4}, "full2");
        chk("cnt2", 32'(retire_cnt), 32'd2);

        stage_skip_mask = 5'b01000;
        runInstr('{0, 1, 2, 4}, "skip3");
        chk("cnt3", 32'(retire_cnt), 32'd3);
        stage_skip_mask = 5'b01100;
        runInstr('{0, 1, 4}, "skip23");
        chk("cnt4", 32'(retire_cnt), 32'd4);
        stage_skip_mask = 5'b10011;
        runInstr('{0, 1, 2, 3, 4}, "forced");
        chk("cnt5", 32'(retire_cnt), 32'd5);

        // Mask captured at decode must persist after the input changes.
        stage_skip_mask = 5'b01000;
        cyc();
        cyc();
        stage_skip_mask = 5'b00000;
        #1;
        chk("latch en2", 32'(stage_en), 32'b00100);
        cyc();
        #1;
        chk("latch en4", 32'(stage_en), 32'b10000);
        chk("latch retire", 32'(retire), 32'h1);
        cyc();
        runInstr('{0, 1, 2, 3, 4}, "cleared");
        chk("cnt7", 32'(retire_cnt), 32'd7);

        cyc();
        cyc();
        cyc();
        stage_ready = 5'b10111;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall en", 32'(stage_en), 32'b01000);
            chk("stall adv", 32'(stage_adv), 32'h0);
            cyc();
        end
        stage_ready = 5'b11111;
        #1;
        chk("stall release en", 32'(stage_en), 32'b01000);
        chk("stall release adv", 32'(stage_adv), 32'b01000);
        cyc();
        runInstr('{4}, "stall tail");
        chk("cnt8", 32'(retire_cnt), 32'd8);

        flush       = 1'b1;
        stage_ready = 5'b00001;
        #1;
        chk("flush s0 adv", 32'(stage_adv), 32'b00001);
        cyc();
        flush       = 1'b0;
        stage_ready = 5'b11111;
        #1;
        chk("flush s0 ignored", 32'(stage_en), 32'b00010);
        cyc();
        flush = 1'b1;
        #1;
        chk("flush s2 en", 32'(stage_en), 32'b00100);
        cyc();
        #1;
        chk("flush to pcu", 32'(stage_en), 32'b10000);
        chk("flush retire", 32'(retire), 32'h1);
        cyc();
        #1;
        chk("flush last ignored", 32'(stage_en), 32'b00001);
        flush = 1'b0;
        chk("cnt9", 32'(retire_cnt), 32'd9);

        cyc();
        cyc();
        run = 1'b0;
        #1;
        chk("rundrop en2", 32'(stage_en), 32'b00100);
        cyc();
        runInstr('{3, 4}, "rundrop");
        #1;
        chk("idle en", 32'(stage_en), 32'h0);
        chk("idle busy", 32'(busy), 32'h0);
        chk("idle cur", 32'(cur_stage), 32'h0);
        chk("cnt10", 32'(retire_cnt), 32'd10);
        cyc();
        run = 1'b1;
        #1;
        chk("idle hold en", 32'(stage_en), 32'h0);
        cyc();
        #1;
        chk("restart en", 32'(stage_en), 32'b00001);
        chk("restart busy", 32'(busy), 32'h1);

        cyc();
        cyc();
        cyc();
        #1;
        chk("pre-reset en", 32'(stage_en), 32'b01000);
        nreset = 1'b0;
        #1;
        chk("async en", 32'(stage_en), 32'h0);
        chk("async busy", 32'(busy), 32'h0);
        chk("async cnt", 32'(retire_cnt), 32'h0);
        chk("async adv", 32'(stage_adv), 32'h0);
        chk("async cur", 32'(cur_stage), 32'h0);
        nreset = 1'b1;
        cyc();

        for (int n = 0; n < 15; n++) begin
            runInstr('{0, 1, 2, 3, 4}, "wrap");
        end
        chk("cnt max", 32'(retire_cnt), 32'hF);
        runInstr('{0, 1, 2, 3, 4}, "wrap last");
        chk("cnt wrapped", 32'(retire_cnt), 32'h0);
        chk("no fault", 32'(fault), 32'h0);

`ifdef CPU_SEQ_STALL_TIMEOUT_EN
        cyc();
        cyc();
        cyc();
        stage_ready = 5'b10111;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("to stall en", 32'(stage_en), 32'b01000);
            chk("to no fault", 32'(fault), 32'h0);
            cyc();
        end
        #1;
        chk("to fault", 32'(fault), 32'h1);
        chk("to en", 32'(stage_en), 32'h0);
        chk("to busy", 32'(busy), 32'h0);
        stage_ready = 5'b11111;
        cyc();
        cyc();
        #1;
        chk("to sticky", 32'(fault), 32'h1);
        chk("to sticky en", 32'(stage_en), 32'h0);
        nreset = 1'b0;
        #1;
        chk("to cleared", 32'(fault), 32'h0);
        nreset = 1'b1;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cpu_stage_sequencer.md
Name: cpu_stage_sequencer

Overview:
- Parametrised multicycle control sequencer for the ARM core. It replaces the fixed 5-state fetch/regfetch/execute/datamem/PCupdate controller.
- Steps an instruction through NUM_STAGES stages, one at a time.
- Each stage handshakes with its datapath block. Stages the decoder marks unused are skipped. A taken branch flushes straight to the last (PC-update) stage.
- Issues per-stage clock-enables (stage_adv), not gated clocks. Stage registers stay on clk.

Parameters:
- NUM_STAGES, 5, number of stages; legal 3..16; stage NUM_STAGES-1 is always PC update.
- DECODE_STAGE, 1, stage whose completion latches the skip mask and flush eligibility; legal 0..NUM_STAGES-2.
- CNT_W, 32, width of the retired-instruction counter.
- TIMEOUT_CYCLES, 255, stall limit per stage (used only with the optional feature); legal >= 1.

Ports:
- clk  in  1  system clock
- nreset  in  1  asynchronous active-low reset
- run  in  1  level; 1 = keep issuing instructions
- stage_ready  in  NUM_STAGES  per-stage done; bit k sampled only while in stage k
- stage_skip_mask  in  NUM_STAGES  from decoder; 1 = skip stage; sampled on stage_adv[DECODE_STAGE]
- flush  in  1  branch taken; sampled only on a cycle with any stage_adv
- stage_en  out  NUM_STAGES  one-hot, current stage; all-zero when idle or faulted
- stage_adv  out  NUM_STAGES  stage_en & stage_ready; combinational clock-enable for the stage's output register
- cur_stage  out  $clog2(NUM_STAGES)  index of current stage; 0 when not running
- busy  out  1  1 while an instruction is in flight
- retire  out  1  one-cycle pulse; last stage completing
- retire_cnt  out  CNT_W  retired instruction count; wraps modulo 2^CNT_W
- fault  out  1  sticky stall-timeout error

Behaviour:
- Reset (nreset=0, async): state IDLE. stage_en=0, stage_adv=0, cur_stage=0, busy=0, retire=0, retire_cnt=0, fault=0, skip latch=0.
- States: IDLE, RUN(k), FAULT. Encoded as a state plus a stage index.
- IDLE: run=1 -> RUN(0) on the next edge. No stage_en is asserted during the IDLE cycle.
- RUN(k):
  - stage_en[k]=1 and busy=1.
  - Stage held while stage_ready[k]=0; no limit without the feature.
  - On stage_adv[k], the next state is chosen in priority order:
    1. k = NUM_STAGES-1: retire pulses the same cycle and retire_cnt increments at the edge. Next is RUN(0) if run=1, else IDLE.
    2. flush=1 and DECODE_STAGE <= k < NUM_STAGES-1: next is RUN(NUM_STAGES-1).
    3. Otherwise: next is the lowest j > k with effective skip[j]=0.
- Effective skip:
  - The skip latch loads stage_skip_mask on stage_adv[DECODE_STAGE].
  - Bits 0..DECODE_STAGE and bit NUM_STAGES-1 are forced 0; those stages are never skipped.
  - When k = DECODE_STAGE, the next-stage search uses the incoming mask directly (same-cycle bypass).
  - The latch clears on retire.
- Latency: one cycle per non-skipped stage when ready is held high. Min instruction = DECODE_STAGE+2 cycles; max = NUM_STAGES cycles plus stalls.
- run dropped mid-instruction: the current instruction completes and retires, then the block enters IDLE. run has no effect on a stage in progress.
- flush in stages before DECODE_STAGE or in the last stage: ignored.
- stage_ready bits for non-current stages: ignored.
- retire_cnt wrap: all-ones + 1 -> 0; no flag.
- Reset mid-instruction: immediate return to reset values. No partial retire is counted.

Optional Feature:
- Macro: CPU_SEQ_STALL_TIMEOUT_EN.
- Defined:
  - A wait counter of width $clog2(TIMEOUT_CYCLES+1) runs in each RUN(k). It clears on stage entry and on stage_adv, and increments each cycle stage_ready[k]=0.
  - On reaching TIMEOUT_CYCLES, the next state is FAULT and fault=1 (sticky).
  - FAULT: stage_en=0, busy=0, no retire. It exits only via nreset.
- Undefined: no counter logic; fault tied 0; stalls are unbounded.

Decomposition:
- Shared package cpu_seq_pkg:
  - state enum (IDLE, RUN, FAULT);
  - default stage index constants STG_IFETCH=0, STG_REGFETCH=1, STG_EXECUTE=2, STG_DATAMEM=3, STG_PCUPDATE=4;
  - a function returning the stage-index width.
- One combinational sub-module, seq_next_stage: inputs current index, effective skip mask and flush qualifier; outputs next index and a wrap flag. It is a priority search over NUM_STAGES.

Test Plan (NUM_STAGES=5, DECODE_STAGE=1; timeout case uses TIMEOUT_CYCLES=8):
- Reset released, run=1, ready=5'b11111, skip=0 -> stage_en goes 00001,00010,00100,01000,10000,00001. retire pulses in the 10000 cycle; retire_cnt=1, then 2 after 10 cycles.
- skip=5'b01000 at stage 1 -> sequence 0,1,2,4: 4 cycles per instruction; skip=5'b01100 -> 0,1,4: 3 cycles. Skip bits 0, 1 and 4 forced to 1 have no effect.
- ready[3] low for 3 cycles -> stage_en=01000 held 4 cycles; stage_adv[3] asserted exactly once, in the 4th.
- flush=1 with stage_adv[2] -> next stage_en=10000. flush=1 with stage_adv[0] -> ignored; next is 00010.
- run=0 during stage 2 -> stages 3 and 4 complete, retire pulses, then IDLE with busy=0, stage_en=0. run=1 -> stage 0 one cycle later.
- nreset=0 asynchronously during stage 3 -> all outputs reach reset values before the next edge. With CPU_SEQ_STALL_TIMEOUT_EN: ready[3]=0 for 8 cycles -> fault=1, stage_en=0, held until nreset.
